ehr_bypass_fifo: RTL

EHR_BYPASS_FIFO -- requirements
Module: ehr_bypass_fifo

---
 rtl/ehr_bypass_fifo.sv | 96 +++++++++
 1 files changed

// File: rtl/ehr_bypass_fifo.sv
// rtl/ehr_bypass_fifo.sv - circular-buffer FIFO with registered enq_ready
// Optional empty-FIFO enq-to-deq bypass when EHR_BYPASS_FIFO_BYPASS_EN is defined.
module ehr_bypass_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     enq_valid,
   output logic                     enq_ready,
   input  logic [WIDTH-1:0]         enq_data,
   output logic                     deq_valid,
   input  logic                     deq_ready,
   output logic [WIDTH-1:0]         deq_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_head;
   logic [AW-1:0]    r_tail;
   logic [CW-1:0]    r_count;
   logic [CW-1:0]    w_count_nxt;

   logic w_empty;
   logic w_full;
   logic w_enq_fire;
   logic w_deq_fire;
   logic w_pass;
   logic w_do_enq;
   logic w_do_deq;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == FULL_COUNT);
   assign enq_ready = !w_full;
   assign count     = r_count;

`ifdef EHR_BYPASS_FIFO_BYPASS_EN
   // Empty FIFO presents the producer's word directly to the consumer.
   assign deq_valid = w_empty ? enq_valid : 1'b1;
   assign deq_data  = w_empty ? (enq_valid ? enq_data : '0) : r_mem[r_head];
   assign w_pass    = w_empty & w_enq_fire & w_deq_fire;
`else
   assign deq_valid = !w_empty;
   assign deq_data  = deq_valid ? r_mem[r_head] : '0;
   assign w_pass    = 1'b0;
`endif

   assign w_enq_fire = enq_valid & enq_ready;
   assign w_deq_fire = deq_valid & deq_ready;
   // A passed-through word touches neither memory, pointers nor count.
   assign w_do_enq   = w_enq_fire & !w_pass;
   assign w_do_deq   = w_deq_fire & !w_pass;

   always_comb begin
      w_count_nxt = r_count;
      if (clear) begin
         w_count_nxt = '0;
      end else if (w_do_enq && !w_do_deq) begin
         w_count_nxt = r_count + CNT_ONE;
      end else if (!w_do_enq && w_do_deq) begin
         w_count_nxt = r_count - CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_count <= w_count_nxt;
         if (clear) begin
            r_head <= '0;
            r_tail <= '0;
         end else begin
            if (w_do_enq) r_tail <= r_tail + PTR_ONE;
            if (w_do_deq) r_head <= r_head + PTR_ONE;
         end
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (w_do_enq && !clear) begin
         r_mem[r_tail] <= enq_data;
      end
   end

endmodule
